// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter (shift_pipe).
// Payload fields are sized for the largest supported operand; each stage
// uses only the low WIDTH bits of data.
package shift_pkg;

    localparam int unsigned MAX_WIDTH   = 64;
    localparam int unsigned MAX_SHAMT_W = 6;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    // Everything that travels with an operand through one stage register.
    typedef struct packed {
        logic [MAX_WIDTH-1:0]   data;
        shift_op_e              op;
        logic [MAX_SHAMT_W-1:0] shamt;
        logic                   carry;
        logic                   valid;
    } stage_pl_t;

    // Number of mux levels owned by stage idx; earlier stages absorb the remainder.
    function automatic int unsigned stage_levels(
        input int unsigned levels,
        input int unsigned stages,
        input int unsigned idx
    );
        return (levels / stages) + ((idx < (levels % stages)) ? 32'd1 : 32'd0);
    endfunction

    // Index of the first mux level owned by stage idx.
    function automatic int unsigned stage_lo(
        input int unsigned levels,
        input int unsigned stages,
        input int unsigned idx
    );
        return (idx * (levels / stages)) +
               ((idx < (levels % stages)) ? idx : (levels % stages));
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of shift_pipe: mux levels LO..HI (inclusive) followed by
// a payload register that loads on the global advance strobe.
// Rotate wrap logic is only built when SHIFT_PIPE_ROTATE_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LO    = 0,
    parameter int unsigned HI    = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_advance,
    input  stage_pl_t i_pl,
    output stage_pl_t o_pl
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned SEL_W = $clog2(MAX_SHAMT_W);

    logic [WIDTH-1:0]       w_data;
    logic                   w_carry;
    logic [MAX_SHAMT_W-1:0] w_shamt;
    int unsigned            w_amt;
    stage_pl_t              w_next;
    stage_pl_t              r_pl;
    logic                   w_unused;

    // Apply this stage's levels LSB first; each active level updates data and carry.
    always_comb begin
        w_data  = i_pl.data[WIDTH-1:0];
        w_carry = i_pl.carry;
        w_shamt = i_pl.shamt;
        w_amt   = 32'd0;
        for (int unsigned j = LO; j <= HI; j++) begin
            w_amt = 32'd1 << j;
            if (i_pl.shamt[SEL_W'(j)]) begin
                // Consumed shift bits are cleared so the payload holds only what remains.
                w_shamt[SEL_W'(j)] = 1'b0;
                case (i_pl.op)
                    OP_SLL: begin
                        w_carry = w_data[IDX_W'(WIDTH - w_amt)];
                        w_data  = w_data << w_amt;
                    end
                    OP_SRL: begin
                        w_carry = w_data[IDX_W'(w_amt - 32'd1)];
                        w_data  = w_data >> w_amt;
                    end
                    OP_SRA: begin
                        w_carry = w_data[IDX_W'(w_amt - 32'd1)];
                        w_data  = WIDTH'($signed(w_data) >>> w_amt);
                    end
`ifdef SHIFT_PIPE_ROTATE_EN
                    OP_ROR: begin
                        w_data  = (w_data >> w_amt) | (w_data << (WIDTH - w_amt));
                        w_carry = w_data[WIDTH-1];
                    end
`endif
                    default: begin
                        // Rotate disabled: operand passes through with carry untouched (0).
                    end
                endcase
            end
        end
        w_next       = i_pl;
        w_next.data  = MAX_WIDTH'(w_data);
        w_next.shamt = w_shamt;
        w_next.carry = w_carry;
    end

    // Payload register: cleared by synchronous reset, frozen while the pipe stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pl <= '0;
        end else if (i_advance) begin
            r_pl <= w_next;
        end
    end

    assign o_pl = r_pl;

    // Operand bits above WIDTH are always zero and carry no information.
    assign w_unused = ^(i_pl.data >> WIDTH);

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready
// handshake and a single global stall. log2(WIDTH) mux levels are spread
// over STAGES register stages.
// Optional feature macro: SHIFT_PIPE_ROTATE_EN (op 11 rotates right when
// defined, otherwise passes the operand through unshifted with carry 0).
module shift_pipe
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH   = 16,
    parameter  int unsigned STAGES  = 2,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_carry
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    stage_pl_t w_in_pl;
    stage_pl_t w_stage_pl [STAGES];
    stage_pl_t w_out_pl;
    logic      w_advance;
    logic      w_unused;

    // Package the incoming request as the first stage's payload.
    always_comb begin
        w_in_pl       = '0;
        w_in_pl.data  = MAX_WIDTH'(in_a);
        w_in_pl.op    = shift_op_e'(in_op);
        w_in_pl.shamt = MAX_SHAMT_W'(in_shamt);
        w_in_pl.carry = 1'b0;
        w_in_pl.valid = in_valid;
    end

    // Chain of stages; every register loads together on advance, bubbles included.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned S_LO = stage_lo(LEVELS, STAGES, unsigned'(s));
        localparam int unsigned S_HI = S_LO + stage_levels(LEVELS, STAGES, unsigned'(s)) - 32'd1;

        stage_pl_t w_stage_in;

        if (s == 0) begin : g_first
            assign w_stage_in = w_in_pl;
        end else begin : g_chain
            assign w_stage_in = w_stage_pl[s-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .LO    (S_LO),
            .HI    (S_HI)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_advance (w_advance),
            .i_pl      (w_stage_in),
            .o_pl      (w_stage_pl[s])
        );
    end

    assign w_out_pl = w_stage_pl[STAGES-1];

    // Global stall: the whole pipe moves unless a finished result is being held.
    assign w_advance = !w_out_pl.valid || out_ready;
    assign in_ready  = w_advance;

    assign out_valid  = w_out_pl.valid;
    assign out_result = w_out_pl.data[WIDTH-1:0];
    assign out_carry  = w_out_pl.carry;
    assign out_zero   = (w_out_pl.data[WIDTH-1:0] == '0);

    // After the last stage the op and remaining shift amount are no longer needed.
    assign w_unused = ^{w_out_pl.op, w_out_pl.shamt, (w_out_pl.data >> WIDTH)};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: a WIDTH=16/STAGES=2 instance for the
// handshake and flag scenarios, plus WIDTH=32 instances with STAGES 1, 3, 5
// swept against a direct arithmetic reference.
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [3:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_carry;

    logic        sw_valid;
    logic [1:0]  sw_op;
    logic [31:0] sw_a;
    logic [4:0]  sw_shamt;
    logic        sw_in_ready  [3];
    logic        sw_out_valid [3];
    logic [31:0] sw_result    [3];
    logic        sw_zero      [3];
    logic        sw_carry     [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_shamt(in_shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_carry(out_carry)
    );

    shift_pipe #(.WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid), .in_ready(sw_in_ready[0]), .in_op(sw_op), .in_a(sw_a), .in_shamt(sw_shamt),
        .out_valid(sw_out_valid[0]), .out_ready(1'b1), .out_result(sw_result[0]),
        .out_zero(sw_zero[0]), .out_carry(sw_carry[0])
    );

    shift_pipe #(.WIDTH(32), .STAGES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid), .in_ready(sw_in_ready[1]), .in_op(sw_op), .in_a(sw_a), .in_shamt(sw_shamt),
        .out_valid(sw_out_valid[1]), .out_ready(1'b1), .out_result(sw_result[1]),
        .out_zero(sw_zero[1]), .out_carry(sw_carry[1])
    );

    shift_pipe #(.WIDTH(32), .STAGES(5)) u_s5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid), .in_ready(sw_in_ready[2]), .in_op(sw_op), .in_a(sw_a), .in_shamt(sw_shamt),
        .out_valid(sw_out_valid[2]), .out_ready(1'b1), .out_result(sw_result[2]),
        .out_zero(sw_zero[2]), .out_carry(sw_carry[2])
    );

    // Direct 32-bit reference: {carry, result}.
    function automatic logic [32:0] ref32(input logic [1:0] op, input logic [31:0] a, input int sh);
        logic [31:0] r;
        logic        c;
        r = a;
        c = 1'b0;
        if (sh != 0) begin
            case (op)
                2'd0: begin r = a << sh; c = a[5'(32 - sh)]; end
                2'd1: begin r = a >> sh; c = a[5'(sh - 1)]; end
                2'd2: begin r = 32'($signed(a) >>> sh); c = a[5'(sh - 1)]; end
                default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
                    r = (a >> sh) | (a << (32 - sh));
                    c = r[31];
`endif
                end
            endcase
        end
        return {c, r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = 16'h0; in_shamt = 4'd0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_op = 2'd0; sw_a = 32'h0; sw_shamt = 5'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_result !== 16'h0) begin n_fail++; $display("FAIL reset_out_result: got %h want 0000", out_result); end
        n_tests++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_out_zero: got %b want 1", out_zero); end
        n_tests++; if (out_carry !== 1'b0) begin n_fail++; $display("FAIL reset_out_carry: got %b want 0", out_carry); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        in_valid = 1'b1; in_op = 2'd0; in_a = 16'h8001; in_shamt = 4'd1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early_valid: got %b want 0", out_valid); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b want 1", out_valid); end
        n_tests++; if (out_result !== 16'h0002) begin n_fail++; $display("FAIL latency_sll_result: got %h want 0002", out_result); end
        n_tests++; if (out_carry !== 1'b1) begin n_fail++; $display("FAIL latency_sll_carry: got %b want 1", out_carry); end
        n_tests++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL latency_sll_zero: got %b want 0", out_zero); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [11];
        logic [15:0] as  [11];
        logic [3:0]  shs [11];
        logic [15:0] rs  [11];
        logic        cs  [11];
        ops = '{2'd2,    2'd1,    2'd1,    2'd0,    2'd2,    2'd0,    2'd2,    2'd3,    2'd3,    2'd0,    2'd1};
        as  = '{16'h8000,16'h8000,16'h0001,16'h00FF,16'h800C,16'hA5A5,16'h8000,16'h1234,16'h0001,16'h0180,16'h00F0};
        shs = '{4'd15,   4'd15,   4'd1,    4'd8,    4'd3,    4'd0,    4'd0,    4'd4,    4'd1,    4'd8,    4'd4};
        rs  = '{16'hFFFF,16'h0001,16'h0000,16'hFF00,16'hF001,16'hA5A5,16'h8000,16'h1234,16'h0001,16'h8000,16'h000F};
        cs  = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
`ifdef SHIFT_PIPE_ROTATE_EN
        rs[7] = 16'h4123;
        rs[8] = 16'h8000;
        cs[8] = 1'b1;
`endif
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_op = ops[i]; in_a = as[i]; in_shamt = shs[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_result !== rs[i]) begin
                n_fail++; $display("FAIL directed_%0d_result: got valid=%b %h want valid=1 %h", i, out_valid, out_result, rs[i]);
            end
            n_tests++;
            if (out_carry !== cs[i]) begin
                n_fail++; $display("FAIL directed_%0d_carry: got %b want %b", i, out_carry, cs[i]);
            end
            n_tests++;
            if (out_zero !== (rs[i] == 16'h0)) begin
                n_fail++; $display("FAIL directed_%0d_zero: got %b want %b", i, out_zero, (rs[i] == 16'h0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        int ready_low = 0;
        int cyc = 0;
        while (recv < 8 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 8);
            in_op     = 2'd0;
            in_a      = 16'h0001;
            in_shamt  = 4'(sent);
            #1;
            n_tests++;
            if (in_ready !== (out_ready || !out_valid)) begin
                n_fail++; $display("FAIL b2b_in_ready_cyc%0d: got %b want %b", cyc, in_ready, (out_ready || !out_valid));
            end
            if (!in_ready) ready_low++;
            if (out_valid && out_ready) begin
                n_tests++;
                if (out_result !== (16'h0001 << recv) || out_carry !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_result_%0d: got %h c=%b want %h c=0", recv, out_result, out_carry, (16'h0001 << recv));
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (recv != 8) begin n_fail++; $display("FAIL b2b_count: got %0d results want 8", recv); end
        n_tests++; if (ready_low != 3) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 3", ready_low); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra_output: got valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'd0; in_a = 16'h00F0; in_shamt = 4'd1;
        @(negedge clk);
        in_a = 16'h0F00; in_shamt = 4'd2;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_tests++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL midrst_zero: got %b want 1", out_zero); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_%0d: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_sweep();
        logic [1:0]  v_op [40];
        logic [31:0] v_a  [40];
        logic [4:0]  v_sh [40];
        logic [32:0] v_exp [40];
        int          lat [3];
        int          idx;
        lat = '{1, 3, 5};
        for (int i = 0; i < 40; i++) begin
            if (i < 4) begin
                v_op[i] = 2'(i); v_a[i] = 32'hDEADBEEF; v_sh[i] = 5'd0;
            end else if (i == 4) begin
                v_op[i] = 2'd2; v_a[i] = 32'h80000000; v_sh[i] = 5'd31;
            end else begin
                v_op[i] = 2'($urandom_range(0, 3));
                v_a[i]  = $urandom;
                v_sh[i] = 5'($urandom_range(0, 31));
            end
            v_exp[i] = ref32(v_op[i], v_a[i], int'(v_sh[i]));
        end
        for (int t = 0; t < 46; t++) begin
            for (int k = 0; k < 3; k++) begin
                idx = t - lat[k];
                if (idx >= 0 && idx < 40) begin
                    n_tests++;
                    if (sw_out_valid[k] !== 1'b1 || sw_result[k] !== v_exp[idx][31:0]) begin
                        n_fail++; $display("FAIL sweep_s%0d_v%0d_result: got valid=%b %h want valid=1 %h", lat[k], idx, sw_out_valid[k], sw_result[k], v_exp[idx][31:0]);
                    end
                    n_tests++;
                    if (sw_carry[k] !== v_exp[idx][32] || sw_zero[k] !== (v_exp[idx][31:0] == 32'h0)) begin
                        n_fail++; $display("FAIL sweep_s%0d_v%0d_flags: got c=%b z=%b want c=%b z=%b", lat[k], idx, sw_carry[k], sw_zero[k], v_exp[idx][32], (v_exp[idx][31:0] == 32'h0));
                    end
                end else begin
                    n_tests++;
                    if (sw_out_valid[k] !== 1'b0) begin
                        n_fail++; $display("FAIL sweep_s%0d_t%0d_idle: got valid %b want 0", lat[k], t, sw_out_valid[k]);
                    end
                end
            end
            if (t < 40) begin
                sw_valid = 1'b1; sw_op = v_op[t]; sw_a = v_a[t]; sw_shamt = v_sh[t];
            end else begin
                sw_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
